// File: rtl/btn_evt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | btn_evt_pkg                                                                |
// | Shared constants and arbiter state encoding for the button event block.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package btn_evt_pkg;

  localparam int N_DEFAULT          = 5;
  localparam int DEB_CYCLES_DEFAULT = 1_000_000;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | btn_debounce_edge                                                          |
// | Two-flop synchroniser, debounce counter and one-cycle press (rise) pulse.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module btn_debounce_edge
  import btn_evt_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_btn,
  output logic o_rise
);

  localparam int              c_cnt_w = $clog2(DEB_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DEB_CYCLES - 1);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_stable;
  logic                r_rise;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                w_diff;
  logic                w_flip;

  assign w_diff = r_sync2 ^ r_stable;
  // The DEB_CYCLES-th consecutive disagreeing cycle accepts the new level.
  assign w_flip = w_diff && (r_cnt == c_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_rise  <= w_flip & r_sync2;
      if (w_flip) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/btn_event_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | btn_event_arbiter                                                          |
// | Debounced button presses latched per channel, served round-robin over a    |
// | valid/ready event port with sticky per-channel overrun flags.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module btn_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter  int N          = N_DEFAULT,
  parameter  int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  localparam int IDW        = $clog2(N)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   btn,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  input  logic           evt_ready,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overrun,
  input  logic           clr_overrun
);

  arb_state_t     r_state;
  logic           r_valid;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] r_ptr;
  logic [N-1:0]   r_pend;
  logic [N-1:0]   r_ovr;

  logic [N-1:0]   w_rise;
  logic           w_hs;
  logic [N-1:0]   w_clr;
  logic [N-1:0]   w_ovr_set;
  logic [IDW-1:0] w_sel;
  int             w_best;

  for (genvar g = 0; g < N; g++) begin : g_ch
    btn_debounce_edge #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rstn   (rstn),
      .i_btn  (btn[g]),
      .o_rise (w_rise[g])
    );
  end

  assign w_hs      = r_valid & evt_ready;
  assign w_clr     = w_hs ? (N'(1) << r_id) : '0;
  // A press landing in the same cycle as its own delivery re-pends cleanly.
  assign w_ovr_set = w_rise & r_pend & ~w_clr;

  // Smallest wrap-around distance from ptr+1 wins.
  always_comb begin
    w_sel  = '0;
    w_best = N;
    for (int i = 0; i < N; i++) begin
      if (r_pend[i] && (((i + N - 1 - int'(r_ptr)) % N) < w_best)) begin
        w_best = (i + N - 1 - int'(r_ptr)) % N;
        w_sel  = IDW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend <= '0;
      r_ovr  <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_rise;
      r_ovr  <= clr_overrun ? w_ovr_set : (r_ovr | w_ovr_set);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|r_pend) begin
            r_id    <= w_sel;
            r_valid <= 1'b1;
            r_state <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (evt_ready) begin
            r_ptr   <= r_id;
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign evt_valid = r_valid;
  assign evt_id    = r_id;
  assign pending   = r_pend;
  assign overrun   = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_btn_event_arbiter                                                       |
// | Directed bench with a cycle model of the press/arbitration rules.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_btn_event_arbiter;

  localparam int N   = 4;
  localparam int DEB = 4;

  logic         clk         = 1'b0;
  logic         rstn        = 1'b0;
  logic [N-1:0] btn         = '0;
  logic         evt_ready   = 1'b0;
  logic         clr_overrun = 1'b0;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic [N-1:0] pending;
  logic [N-1:0] overrun;

  int checks = 0;
  int errors = 0;

  btn_event_arbiter #(.N(N), .DEB_CYCLES(DEB)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .btn         (btn),
    .evt_valid   (evt_valid),
    .evt_id      (evt_id),
    .evt_ready   (evt_ready),
    .pending     (pending),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per channel, a press is accepted once the two-cycle-delayed button
  // has disagreed with the accepted level for DEB edges; it pends one edge later.
  int           m_d1[N], m_d2[N], m_stab[N], m_run[N], m_rdue[N];
  logic [N-1:0] m_pend, m_ovr;
  int           m_valid, m_id, m_ptr;
  logic [N-1:0] mo_old, mo_clr, mo_oset;
  int           mo_sync, mo_idx;
  bit           mo_found;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        m_d1[i] = 0; m_d2[i] = 0; m_stab[i] = 0; m_run[i] = 0; m_rdue[i] = 0;
      end
      m_pend = '0; m_ovr = '0; m_valid = 0; m_id = 0; m_ptr = 0;
    end else begin
      mo_old  = m_pend;
      mo_clr  = '0;
      mo_oset = '0;
      if (m_valid != 0 && evt_ready) mo_clr[m_id] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (m_rdue[i] != 0 && mo_old[i] && !mo_clr[i]) mo_oset[i] = 1'b1;
        m_pend[i] = (mo_old[i] && !mo_clr[i]) || (m_rdue[i] != 0);
      end
      m_ovr = clr_overrun ? mo_oset : (m_ovr | mo_oset);
      if (m_valid == 0) begin
        mo_found = 0;
        for (int off = 1; off <= N; off++) begin
          mo_idx = (m_ptr + off) % N;
          if (!mo_found && mo_old[mo_idx]) begin
            mo_found = 1; m_id = mo_idx; m_valid = 1;
          end
        end
      end else if (evt_ready) begin
        m_ptr = m_id; m_valid = 0;
      end
      for (int i = 0; i < N; i++) begin
        mo_sync = m_d2[i];
        m_d2[i] = m_d1[i];
        m_d1[i] = int'(btn[i]);
        m_rdue[i] = 0;
        if (mo_sync != m_stab[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_stab[i] = mo_sync; m_run[i] = 0;
            if (mo_sync != 0) m_rdue[i] = 1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_valid", int'(evt_valid), m_valid);
    chk("model_pending", int'(pending), int'(m_pend));
    chk("model_overrun", int'(overrun), int'(m_ovr));
    if (m_valid != 0) chk("model_id", int'(evt_id), m_id);
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  // Returns the index of the first posedge (0-based) after which evt_valid is high, or -1.
  task automatic wait_valid(input int limit, output int edges);
    edges = -1;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk); #1;
      if (evt_valid) begin edges = k; break; end
    end
  endtask

  initial begin
    int e;
    int ids[$];
    int cyc[$];
    int exp_rr[4];
    int pf;
    exp_rr = '{1, 2, 3, 0};

    step(3);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overrun", int'(overrun), 0);
    rstn = 1'b1;
    step(2);

    // Single press with a ready consumer
    btn = 4'b0010; evt_ready = 1'b1;
    wait_valid(20, e);
    chk("press_latency", e, 7);
    chk("press_id", int'(evt_id), 1);
    @(posedge clk); #1;
    chk("press_one_cycle", int'(evt_valid), 0);
    chk("press_pend_clr", int'(pending), 0);
    btn = '0;
    step(12);

    // Glitch rejection then minimum accepted pulse
    btn = 4'b0001; step(3); btn = '0;
    wait_valid(15, e);
    chk("glitch3_none", e, -1);
    chk("glitch3_pend", int'(pending), 0);
    step(2);
    btn = 4'b0001; step(4); btn = '0;
    wait_valid(15, e);
    chk("glitch4_latency", e, 3);
    chk("glitch4_id", int'(evt_id), 0);
    step(10);

    // Round-robin: all four pending with ptr at 0
    evt_ready = 1'b0;
    btn = 4'b1111;
    pf = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (pending == 4'b1111) begin pf = 1; break; end
    end
    chk("rr_all_pending", pf, 1);
    btn = '0;
    evt_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (evt_valid && evt_ready) begin ids.push_back(int'(evt_id)); cyc.push_back(c); end
    end
    chk("rr_count", ids.size(), 4);
    for (int j = 0; j < 4 && j < ids.size(); j++) begin
      chk("rr_order", ids[j], exp_rr[j]);
      if (j > 0) chk("rr_spacing", cyc[j] - cyc[j-1], 2);
    end
    step(10);

    // Backpressure holds the offered event
    evt_ready = 1'b0;
    btn = 4'b1000;
    wait_valid(20, e);
    chk("bp_seen", e, 7);
    btn = '0;
    for (int j = 0; j < 10; j++) begin
      step(1);
      chk("bp_valid", int'(evt_valid), 1);
      chk("bp_id", int'(evt_id), 3);
    end
    evt_ready = 1'b1;
    step(1);
    chk("bp_drop", int'(evt_valid), 0);
    chk("bp_pend", int'(pending), 0);

    // Overrun on channel 2 while its event is blocked
    evt_ready = 1'b0;
    step(10);
    btn = 4'b0100;
    wait_valid(20, e);
    chk("ovr_first_id", int'(evt_id), 2);
    btn = '0; step(10);
    btn = 4'b0100; step(10);
    btn = '0;
    chk("ovr_set", int'(overrun), 4);
    chk("ovr_pend", int'(pending), 4);
    clr_overrun = 1'b1; step(1); clr_overrun = 1'b0;
    chk("ovr_clear", int'(overrun), 0);

    // Reset mid-offer with channel 1 held through it
    btn = 4'b0010;
    step(10);
    chk("rmo_pre_valid", int'(evt_valid), 1);
    chk("rmo_pre_pend", int'(pending), 6);
    rstn = 1'b0;
    #1;
    chk("rmo_valid", int'(evt_valid), 0);
    chk("rmo_pending", int'(pending), 0);
    chk("rmo_overrun", int'(overrun), 0);
    step(3);
    rstn = 1'b1;
    wait_valid(20, e);
    chk("rmo_latency", e, DEB + 3);
    chk("rmo_id", int'(evt_id), 1);
    evt_ready = 1'b1;
    btn = '0;
    step(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
